// File: rtl/msi_irq_queue_pkg.sv
// Shared tile definitions for the MSI interrupt queue: code width shared with
// the SFR block's msi_code output, status counter width and a saturating
// increment helper.
package msi_irq_queue_pkg;

  localparam int MSI_CODE_W = 8;
  localparam int DROP_CNT_W = 8;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == '1) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/msi_irq_queue_if.sv
// MSI push / IRQ pop handshake between the SFR block, the core and the queue.
// master = SFR+core side, slave = msi_irq_queue.
interface msi_irq_queue_if
  import msi_irq_queue_pkg::*;
#(
  parameter int CODE_W = MSI_CODE_W
);
  logic              msi_req_i;
  logic [CODE_W-1:0] msi_code_bi;
  logic              irq_req_o;
  logic [CODE_W-1:0] irq_code_bo;
  logic              irq_ack_i;

  modport master (
    output msi_req_i, msi_code_bi, irq_ack_i,
    input  irq_req_o, irq_code_bo
  );

  modport slave (
    input  msi_req_i, msi_code_bi, irq_ack_i,
    output irq_req_o, irq_code_bo
  );
endinterface

// File: rtl/msi_irq_queue_fifo.sv
// Generic DEPTH-entry circular buffer: pointers, occupancy, full/empty.
// The caller guarantees push_i is only raised when a slot is free (or a pop
// happens in the same cycle); clr_i is a plain synchronous clear.
module msi_fifo #(
  parameter  int DEPTH  = 4,
  parameter  int CODE_W = 8,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int LVL_W  = PTR_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [CODE_W-1:0] wdata_bi,
  output logic [CODE_W-1:0] head_bo,
  output logic [CODE_W-1:0] next_bo,
  output logic [LVL_W-1:0]  level_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [PTR_W-1:0]  rptr_inc;
  logic [LVL_W-1:0]  level_q, level_d;

  assign rptr_inc = rptr_q + PTR_W'(1);

  // Next-state for pointers and occupancy; clear wins over push/pop.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (clr_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + PTR_W'(1);
      if (pop_i)  rptr_d = rptr_inc;
      case ({push_i, pop_i})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Control state register with async reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage array; data only, no reset needed since level gates validity.
  always_ff @(posedge clk_i) begin
    if (push_i && !clr_i) mem_q[wptr_q] <= wdata_bi;
  end

  assign head_bo = mem_q[rptr_q];
  assign next_bo = mem_q[rptr_inc];
  assign level_o = level_q;
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);

endmodule

// File: rtl/msi_irq_queue.sv
// MSI interrupt queue: buffers MSI codes from the SFR block and presents them
// to the core as a registered level request with code. Adds drop/overflow
// status and a synchronous flush on top of the generic msi_fifo.
module msi_irq_queue
  import msi_irq_queue_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int CODE_W = MSI_CODE_W,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  msi_irq_queue_if.slave        bus,
  output logic [LVL_W-1:0]      level_o,
  output logic                  ovf_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  logic                  push_ok, pop_ok, drop;
  logic                  fifo_full, fifo_empty;
  logic [CODE_W-1:0]     fifo_head, fifo_next;
  logic [LVL_W-1:0]      fifo_level;

  logic                  irq_req_q, irq_req_d;
  logic [CODE_W-1:0]     irq_code_q, irq_code_d;
  logic                  ovf_q, ovf_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // A pop needs a presented head; a push into a full queue is only accepted
  // when the same cycle frees a slot. Flush suppresses both.
  assign pop_ok  = bus.irq_ack_i & irq_req_q & ~fifo_empty & ~flush_i;
  assign push_ok = bus.msi_req_i & (~fifo_full | pop_ok) & ~flush_i;
  assign drop    = bus.msi_req_i & fifo_full & ~pop_ok & ~flush_i;

  msi_fifo #(
    .DEPTH  (DEPTH),
    .CODE_W (CODE_W)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (flush_i),
    .push_i   (push_ok),
    .pop_i    (pop_ok),
    .wdata_bi (bus.msi_code_bi),
    .head_bo  (fifo_head),
    .next_bo  (fifo_next),
    .level_o  (fifo_level),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  // Predict next-cycle head/request so the outputs can be registered.
  always_comb begin
    irq_req_d  = irq_req_q;
    irq_code_d = irq_code_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (flush_i) begin
      irq_req_d  = 1'b0;
      irq_code_d = '0;
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (drop) begin
        ovf_d      = 1'b1;
        drop_cnt_d = sat_inc(drop_cnt_q);
      end
      if (pop_ok) begin
        // With one entry left the only possible next head is a same-cycle push.
        if (fifo_level == LVL_W'(1)) begin
          irq_req_d = push_ok;
          if (push_ok) irq_code_d = bus.msi_code_bi;
        end else begin
          irq_code_d = fifo_next;
        end
      end else if (!irq_req_q && push_ok) begin
        irq_req_d  = 1'b1;
        irq_code_d = bus.msi_code_bi;
      end else if (irq_req_q) begin
        irq_code_d = fifo_head;
      end
    end
  end

  // Output and status registers with async reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_req_q  <= 1'b0;
      irq_code_q <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      irq_req_q  <= irq_req_d;
      irq_code_q <= irq_code_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.irq_req_o   = irq_req_q;
  assign bus.irq_code_bo = irq_code_q;
  assign level_o         = fifo_level;
  assign ovf_o           = ovf_q;
  assign drop_cnt_o      = drop_cnt_q;

endmodule

// File: tb/tb_msi_irq_queue.sv
// Bench for msi_irq_queue: vector table plus a FIFO scoreboard model, and
// hand-written sequences for drop saturation and asynchronous reset.
module tb_msi_irq_queue;
  import msi_irq_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             flush_i;
  logic [LVL_W-1:0] level_o;
  logic             ovf_o;
  logic [7:0]       drop_cnt_o;

  msi_irq_queue_if #(.CODE_W(8)) ifc ();

  msi_irq_queue #(.DEPTH(DEPTH), .CODE_W(8)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .bus        (ifc.slave),
    .level_o    (level_o),
    .ovf_o      (ovf_o),
    .drop_cnt_o (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit         req;
    logic [7:0] code;
    bit         ack;
    bit         flush;
    bit         e_req;
    logic [7:0] e_code;
    int         e_lvl;
    bit         e_ovf;
    int         e_drop;
  } vec_t;

  vec_t       tbl[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] sb[$];
  bit         m_ovf = 1'b0;
  int         m_drop = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input bit req, input logic [7:0] code, input bit ack, input bit flush,
                     input bit e_req, input logic [7:0] e_code, input int e_lvl,
                     input bit e_ovf, input int e_drop);
    vec_t v;
    v.req = req; v.code = code; v.ack = ack; v.flush = flush;
    v.e_req = e_req; v.e_code = e_code; v.e_lvl = e_lvl; v.e_ovf = e_ovf; v.e_drop = e_drop;
    tbl.push_back(v);
  endtask

  // One clock: drive inputs, score any pop, update the model, check after edge.
  task automatic step(input bit req, input logic [7:0] code, input bit ack, input bit flush);
    ifc.msi_req_i   = req;
    ifc.msi_code_bi = code;
    ifc.irq_ack_i   = ack;
    flush_i         = flush;
    if (flush) begin
      sb.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      if (ack && sb.size() > 0) begin
        chk("sb_req", {31'b0, ifc.irq_req_o}, 32'd1);
        chk("sb_pop", {24'b0, ifc.irq_code_bo}, {24'b0, sb[0]});
        void'(sb.pop_front());
      end
      if (req) begin
        if (sb.size() < DEPTH) sb.push_back(code);
        else begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
    end
    @(posedge clk_i);
    #1;
    ifc.msi_req_i = 1'b0;
    ifc.irq_ack_i = 1'b0;
    flush_i       = 1'b0;
    chk("m_req",   {31'b0, ifc.irq_req_o}, (sb.size() != 0) ? 32'd1 : 32'd0);
    chk("m_level", {{(32-LVL_W){1'b0}}, level_o}, sb.size());
    chk("m_ovf",   {31'b0, ovf_o}, {31'b0, m_ovf});
    chk("m_drop",  {24'b0, drop_cnt_o}, m_drop);
    if (sb.size() != 0) chk("m_code", {24'b0, ifc.irq_code_bo}, {24'b0, sb[0]});
  endtask

  initial begin
    rst_i           = 1'b1;
    flush_i         = 1'b0;
    ifc.msi_req_i   = 1'b0;
    ifc.msi_code_bi = '0;
    ifc.irq_ack_i   = 1'b0;

    // Single push, full/drop, push+pop at full, flush with push+ack, push+pop at level 1
    add(1, 8'h5A, 0, 0, 1, 8'h5A, 1, 0, 0);
    add(0, 8'h00, 0, 0, 1, 8'h5A, 1, 0, 0);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0);
    add(1, 8'h01, 0, 0, 1, 8'h01, 1, 0, 0);
    add(1, 8'h02, 0, 0, 1, 8'h01, 2, 0, 0);
    add(1, 8'h03, 0, 0, 1, 8'h01, 3, 0, 0);
    add(1, 8'h04, 0, 0, 1, 8'h01, 4, 0, 0);
    add(1, 8'h05, 0, 0, 1, 8'h01, 4, 1, 1);
    add(0, 8'h00, 1, 0, 1, 8'h02, 3, 1, 1);
    add(0, 8'h00, 1, 0, 1, 8'h03, 2, 1, 1);
    add(0, 8'h00, 1, 0, 1, 8'h04, 1, 1, 1);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 1);
    add(0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0);
    add(1, 8'hA1, 0, 0, 1, 8'hA1, 1, 0, 0);
    add(1, 8'hA2, 0, 0, 1, 8'hA1, 2, 0, 0);
    add(1, 8'hA3, 0, 0, 1, 8'hA1, 3, 0, 0);
    add(1, 8'hA4, 0, 0, 1, 8'hA1, 4, 0, 0);
    add(1, 8'h10, 1, 0, 1, 8'hA2, 4, 0, 0);
    add(0, 8'h00, 1, 0, 1, 8'hA3, 3, 0, 0);
    add(0, 8'h00, 1, 0, 1, 8'hA4, 2, 0, 0);
    add(0, 8'h00, 1, 0, 1, 8'h10, 1, 0, 0);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0);
    add(1, 8'h21, 0, 0, 1, 8'h21, 1, 0, 0);
    add(1, 8'h33, 1, 1, 0, 8'h00, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0);
    add(1, 8'h41, 0, 0, 1, 8'h41, 1, 0, 0);
    add(1, 8'h42, 1, 0, 1, 8'h42, 1, 0, 0);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0);

    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_req",   {31'b0, ifc.irq_req_o}, 32'd0);
    chk("rst_code",  {24'b0, ifc.irq_code_bo}, 32'd0);
    chk("rst_level", {{(32-LVL_W){1'b0}}, level_o}, 32'd0);
    chk("rst_ovf",   {31'b0, ovf_o}, 32'd0);
    chk("rst_drop",  {24'b0, drop_cnt_o}, 32'd0);
    rst_i = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].req, tbl[i].code, tbl[i].ack, tbl[i].flush);
      chk($sformatf("vec%0d_req", i), {31'b0, ifc.irq_req_o}, {31'b0, tbl[i].e_req});
      chk($sformatf("vec%0d_level", i), {{(32-LVL_W){1'b0}}, level_o}, tbl[i].e_lvl);
      chk($sformatf("vec%0d_ovf", i), {31'b0, ovf_o}, {31'b0, tbl[i].e_ovf});
      chk($sformatf("vec%0d_drop", i), {24'b0, drop_cnt_o}, tbl[i].e_drop);
      if (tbl[i].e_req)
        chk($sformatf("vec%0d_code", i), {24'b0, ifc.irq_code_bo}, {24'b0, tbl[i].e_code});
    end

    // Drop counter saturation, then flush clears status
    for (int i = 0; i < DEPTH; i++) step(1, 8'hB0 + 8'(i), 0, 0);
    for (int i = 0; i < 300; i++) step(1, 8'(i), 0, 0);
    chk("sat_drop",  {24'b0, drop_cnt_o}, 32'd255);
    chk("sat_ovf",   {31'b0, ovf_o}, 32'd1);
    chk("sat_level", {{(32-LVL_W){1'b0}}, level_o}, 32'd4);
    chk("sat_head",  {24'b0, ifc.irq_code_bo}, 32'hB0);
    step(0, 8'h00, 0, 1);
    chk("fl_drop",  {24'b0, drop_cnt_o}, 32'd0);
    chk("fl_req",   {31'b0, ifc.irq_req_o}, 32'd0);
    chk("fl_level", {{(32-LVL_W){1'b0}}, level_o}, 32'd0);

    // Held flush keeps the queue empty despite pushes
    step(1, 8'h77, 0, 1);
    step(1, 8'h78, 0, 1);
    chk("hold_level", {{(32-LVL_W){1'b0}}, level_o}, 32'd0);

    // Asynchronous reset mid-cycle with three codes queued
    step(1, 8'hE1, 0, 0);
    step(1, 8'hE2, 0, 0);
    step(1, 8'hE3, 0, 0);
    #3;
    rst_i = 1'b1;
    #1;
    chk("arst_req",   {31'b0, ifc.irq_req_o}, 32'd0);
    chk("arst_level", {{(32-LVL_W){1'b0}}, level_o}, 32'd0);
    chk("arst_code",  {24'b0, ifc.irq_code_bo}, 32'd0);
    sb.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    step(1, 8'h5A, 0, 0);
    chk("post_rst_code", {24'b0, ifc.irq_code_bo}, 32'h5A);
    step(0, 8'h00, 1, 0);
    chk("post_rst_req", {31'b0, ifc.irq_req_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
